// File: rtl/ym_mix_pkg.sv
// Shared types and helpers for the stereo frame mixer: accumulator sizing,
// output saturation and pan bit positions.
package ym_mix_pkg;

    localparam int PAN_L = 1;
    localparam int PAN_R = 0;

    function automatic int acc_width(input int sample_w, input int channels);
        return sample_w + 2 + $clog2(channels);
    endfunction

    // Clamp a wide signed value into the two's complement range of 'width' bits.
    function automatic logic signed [63:0] sat_to(input logic signed [63:0] value,
                                                  input int width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (value > hi) return hi;
        if (value < lo) return lo;
        return value;
    endfunction

endpackage

// File: rtl/ym_mix_side.sv
// One output side of the mixer: pan/crossover contribution of the current
// sample plus the running frame accumulator.
module ym_mix_side #(
    parameter int SAMPLE_W = 9,
    parameter int AW       = 14
) (
    input  logic                       MCLK,
    input  logic                       IC,
    input  logic signed [SAMPLE_W-1:0] sample,
    input  logic                       en,
    input  logic                       mode_2612,
    input  logic                       clear,
    input  logic                       load,
    input  logic                       add,
    output logic signed [AW-1:0]       sum
);

    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] ext;
    logic signed [AW-1:0] contrib;

    // In 2612 mode non-negative samples carry a +1 offset even on a muted side.
    always_comb begin
        ext     = AW'(sample);
        contrib = '0;
        if (mode_2612 && !sample[SAMPLE_W-1]) begin
            contrib = en ? ext + AW'(1) : AW'(1);
        end else if (en) begin
            contrib = ext;
        end
        sum = acc + contrib;
    end

    always_ff @(posedge MCLK or negedge IC) begin
        if (!IC) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (load) begin
            acc <= contrib;
        end else if (add) begin
            acc <= sum;
        end
    end

endmodule

// File: rtl/ym_mix_accum.sv
// Stereo frame mixer: sums CHANNELS time-multiplexed samples per side and
// presents one saturated, scaled stereo word per frame on a valid/ready buffer.
module ym_mix_accum
    import ym_mix_pkg::*;
#(
    parameter int CHANNELS = 6,
    parameter int SAMPLE_W = 9,
    parameter int OUT_W    = 16,
    parameter int GAIN_SH  = 0
) (
    input  logic                       MCLK,
    input  logic                       IC,
    input  logic                       sample_valid,
    input  logic signed [SAMPLE_W-1:0] sample,
    input  logic [1:0]                 pan,
    input  logic                       frame_start,
    input  logic                       mode_2612,
    output logic signed [OUT_W-1:0]    out_l,
    output logic signed [OUT_W-1:0]    out_r,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       overrun,
    input  logic                       overrun_clr,
    output logic                       frame_err
);

    localparam int AW = acc_width(SAMPLE_W, CHANNELS);
    localparam int CW = $clog2(CHANNELS + 1);

    logic [CW-1:0]        cnt;
    logic                 complete;
    logic                 load;
    logic                 clear;
    logic signed [AW-1:0] sum_l;
    logic signed [AW-1:0] sum_r;

    // A frame_start sample always opens a new frame, so it can never complete one.
    assign complete = sample_valid && !frame_start && (cnt == CW'(CHANNELS - 1));
    assign load     = sample_valid && frame_start;
    assign clear    = complete || (frame_start && !sample_valid);

    ym_mix_side #(.SAMPLE_W(SAMPLE_W), .AW(AW)) side_l (
        .MCLK      (MCLK),
        .IC        (IC),
        .sample    (sample),
        .en        (pan[PAN_L]),
        .mode_2612 (mode_2612),
        .clear     (clear),
        .load      (load),
        .add       (sample_valid),
        .sum       (sum_l)
    );

    ym_mix_side #(.SAMPLE_W(SAMPLE_W), .AW(AW)) side_r (
        .MCLK      (MCLK),
        .IC        (IC),
        .sample    (sample),
        .en        (pan[PAN_R]),
        .mode_2612 (mode_2612),
        .clear     (clear),
        .load      (load),
        .add       (sample_valid),
        .sum       (sum_r)
    );

    always_ff @(posedge MCLK or negedge IC) begin
        if (!IC) begin
            cnt       <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= frame_start && (cnt != '0);
            if (frame_start) begin
                cnt <= sample_valid ? CW'(1) : '0;
            end else if (complete) begin
                cnt <= '0;
            end else if (sample_valid) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // A completion overwrites the buffer even if it was never consumed.
    always_ff @(posedge MCLK or negedge IC) begin
        if (!IC) begin
            out_l     <= '0;
            out_r     <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (complete) begin
                out_l     <= OUT_W'(sat_to(64'(sum_l) <<< GAIN_SH, OUT_W));
                out_r     <= OUT_W'(sat_to(64'(sum_r) <<< GAIN_SH, OUT_W));
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (complete && out_valid && !out_ready) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ym_mix_accum.sv
// Directed bench for ym_mix_accum: a table of whole-frame vectors checked on a
// GAIN_SH=0 and a GAIN_SH=6 instance, plus hand-written handshake/resync/reset cases.
module tb_ym_mix_accum;

    localparam int CH = 6;
    localparam int SW = 9;
    localparam int OW = 16;

    logic                 MCLK = 1'b0;
    logic                 IC = 1'b0;
    logic                 sample_valid = 1'b0;
    logic signed [SW-1:0] sample = '0;
    logic [1:0]           pan = 2'b00;
    logic                 frame_start = 1'b0;
    logic                 mode_2612 = 1'b0;
    logic                 out_ready = 1'b0;
    logic                 overrun_clr = 1'b0;

    logic signed [OW-1:0] out_l, out_r, out_l6, out_r6;
    logic                 out_valid, overrun, frame_err;
    logic                 out_valid6, overrun6, frame_err6;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 MCLK = ~MCLK;

    ym_mix_accum #(.CHANNELS(CH), .SAMPLE_W(SW), .OUT_W(OW), .GAIN_SH(0)) dut (
        .MCLK(MCLK), .IC(IC), .sample_valid(sample_valid), .sample(sample), .pan(pan),
        .frame_start(frame_start), .mode_2612(mode_2612), .out_l(out_l), .out_r(out_r),
        .out_valid(out_valid), .out_ready(out_ready), .overrun(overrun),
        .overrun_clr(overrun_clr), .frame_err(frame_err)
    );

    ym_mix_accum #(.CHANNELS(CH), .SAMPLE_W(SW), .OUT_W(OW), .GAIN_SH(6)) dut_g6 (
        .MCLK(MCLK), .IC(IC), .sample_valid(sample_valid), .sample(sample), .pan(pan),
        .frame_start(frame_start), .mode_2612(mode_2612), .out_l(out_l6), .out_r(out_r6),
        .out_valid(out_valid6), .out_ready(out_ready), .overrun(overrun6),
        .overrun_clr(overrun_clr), .frame_err(frame_err6)
    );

    typedef struct {
        string      name;
        int         smp;
        logic [1:0] pan;
        logic       mode;
        int         exp_l;
        int         exp_r;
        int         exp_l6;
        int         exp_r6;
    } vec_t;

    vec_t vecs[8];

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Present one valid sample on the next falling edge.
    task automatic applyStimulus(input int smp, input logic [1:0] p, input logic m, input logic fs);
        @(negedge MCLK);
        sample_valid = 1'b1;
        sample       = SW'(smp);
        pan          = p;
        mode_2612    = m;
        frame_start  = fs;
    endtask

    task automatic idle();
        @(negedge MCLK);
        sample_valid = 1'b0;
        frame_start  = 1'b0;
        out_ready    = 1'b0;
        overrun_clr  = 1'b0;
    endtask

    task automatic send_frame(input int smp, input logic [1:0] p, input logic m);
        applyStimulus(smp, p, m, 1'b1);
        repeat (CH - 1) applyStimulus(smp, p, m, 1'b0);
        idle();
    endtask

    task automatic consume();
        @(negedge MCLK);
        out_ready = 1'b1;
        @(negedge MCLK);
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vecs[0] = '{"basic",       10, 2'b11, 1'b0,    60,    60,   3840,   3840};
        vecs[1] = '{"2612_pos",    10, 2'b10, 1'b1,    66,     6,   4224,    384};
        vecs[2] = '{"2612_neg",   -10, 2'b01, 1'b1,     0,   -60,      0,  -3840};
        vecs[3] = '{"max_pos",    255, 2'b11, 1'b0,  1530,  1530,  32767,  32767};
        vecs[4] = '{"max_neg",   -256, 2'b11, 1'b0, -1536, -1536, -32768, -32768};
        vecs[5] = '{"2612_max",   255, 2'b11, 1'b1,  1536,  1536,  32767,  32767};
        vecs[6] = '{"2612_min",  -256, 2'b10, 1'b1, -1536,     0, -32768,      0};
        vecs[7] = '{"2612_mute",    0, 2'b00, 1'b1,     6,     6,    384,    384};

        // Reset state
        repeat (2) @(negedge MCLK);
        checkOutput("rst_out_l", int'(out_l), 0);
        checkOutput("rst_out_r", int'(out_r), 0);
        checkOutput("rst_valid", int'(out_valid), 0);
        checkOutput("rst_overrun", int'(overrun), 0);
        checkOutput("rst_frame_err", int'(frame_err), 0);
        checkOutput("rst_valid_g6", int'(out_valid6), 0);
        IC = 1'b1;

        // Table-driven frames
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].smp, vecs[i].pan, vecs[i].mode, 1'b1);
            repeat (CH - 2) applyStimulus(vecs[i].smp, vecs[i].pan, vecs[i].mode, 1'b0);
            applyStimulus(vecs[i].smp, vecs[i].pan, vecs[i].mode, 1'b0);
            checkOutput({vecs[i].name, "_valid_early"}, int'(out_valid), 0);
            idle();
            checkOutput({vecs[i].name, "_valid"}, int'(out_valid), 1);
            checkOutput({vecs[i].name, "_l"}, int'(out_l), vecs[i].exp_l);
            checkOutput({vecs[i].name, "_r"}, int'(out_r), vecs[i].exp_r);
            checkOutput({vecs[i].name, "_valid_g6"}, int'(out_valid6), 1);
            checkOutput({vecs[i].name, "_l_g6"}, int'(out_l6), vecs[i].exp_l6);
            checkOutput({vecs[i].name, "_r_g6"}, int'(out_r6), vecs[i].exp_r6);
            consume();
            checkOutput({vecs[i].name, "_consumed"}, int'(out_valid), 0);
        end

        // Backpressure: second frame overwrites the first
        send_frame(10, 2'b11, 1'b0);
        checkOutput("bp_first_l", int'(out_l), 60);
        checkOutput("bp_first_overrun", int'(overrun), 0);
        send_frame(20, 2'b11, 1'b0);
        checkOutput("bp_second_l", int'(out_l), 120);
        checkOutput("bp_second_valid", int'(out_valid), 1);
        checkOutput("bp_overrun", int'(overrun), 1);
        consume();
        checkOutput("bp_consumed", int'(out_valid), 0);
        checkOutput("bp_overrun_sticky", int'(overrun), 1);
        @(negedge MCLK);
        overrun_clr = 1'b1;
        @(negedge MCLK);
        overrun_clr = 1'b0;
        checkOutput("bp_overrun_clr", int'(overrun), 0);

        // Completion on the same edge as consumption: no overrun
        send_frame(1, 2'b11, 1'b0);
        checkOutput("cc_first_l", int'(out_l), 6);
        applyStimulus(2, 2'b11, 1'b0, 1'b1);
        repeat (CH - 1) applyStimulus(2, 2'b11, 1'b0, 1'b0);
        out_ready = 1'b1;
        idle();
        checkOutput("cc_l", int'(out_l), 12);
        checkOutput("cc_valid", int'(out_valid), 1);
        checkOutput("cc_overrun", int'(overrun), 0);
        consume();

        // Overrun set wins over a simultaneous clear
        send_frame(1, 2'b11, 1'b0);
        applyStimulus(3, 2'b11, 1'b0, 1'b1);
        repeat (CH - 1) applyStimulus(3, 2'b11, 1'b0, 1'b0);
        overrun_clr = 1'b1;
        idle();
        checkOutput("prio_l", int'(out_l), 18);
        checkOutput("prio_overrun", int'(overrun), 1);
        consume();
        @(negedge MCLK);
        overrun_clr = 1'b1;
        @(negedge MCLK);
        overrun_clr = 1'b0;

        // Resync with a sample: partial frame of three dropped
        applyStimulus(10, 2'b11, 1'b0, 1'b1);
        applyStimulus(10, 2'b11, 1'b0, 1'b0);
        checkOutput("rs_no_err_start", int'(frame_err), 0);
        applyStimulus(10, 2'b11, 1'b0, 1'b0);
        applyStimulus(5, 2'b11, 1'b0, 1'b1);
        applyStimulus(5, 2'b11, 1'b0, 1'b0);
        checkOutput("rs_err_pulse", int'(frame_err), 1);
        applyStimulus(5, 2'b11, 1'b0, 1'b0);
        checkOutput("rs_err_one_cycle", int'(frame_err), 0);
        repeat (3) applyStimulus(5, 2'b11, 1'b0, 1'b0);
        idle();
        checkOutput("rs_valid", int'(out_valid), 1);
        checkOutput("rs_l", int'(out_l), 30);
        checkOutput("rs_r", int'(out_r), 30);
        consume();

        // Resync without a sample
        applyStimulus(7, 2'b11, 1'b0, 1'b1);
        applyStimulus(7, 2'b11, 1'b0, 1'b0);
        @(negedge MCLK);
        sample_valid = 1'b0;
        frame_start  = 1'b1;
        @(negedge MCLK);
        frame_start  = 1'b0;
        checkOutput("rs2_err_pulse", int'(frame_err), 1);
        send_frame(3, 2'b11, 1'b0);
        checkOutput("rs2_l", int'(out_l), 18);
        checkOutput("rs2_no_err", int'(frame_err), 0);
        consume();

        // Asynchronous reset mid-frame with an unconsumed buffer
        send_frame(10, 2'b11, 1'b0);
        checkOutput("ar_pre_valid", int'(out_valid), 1);
        applyStimulus(10, 2'b11, 1'b0, 1'b1);
        repeat (3) applyStimulus(10, 2'b11, 1'b0, 1'b0);
        #2;
        IC = 1'b0;
        #1;
        checkOutput("ar_valid", int'(out_valid), 0);
        checkOutput("ar_l", int'(out_l), 0);
        checkOutput("ar_r", int'(out_r), 0);
        checkOutput("ar_overrun", int'(overrun), 0);
        @(negedge MCLK);
        sample_valid = 1'b0;
        frame_start  = 1'b0;
        IC           = 1'b1;
        repeat (CH) applyStimulus(1, 2'b11, 1'b0, 1'b0);
        idle();
        checkOutput("ar_after_l", int'(out_l), 6);
        checkOutput("ar_after_valid", int'(out_valid), 1);
        checkOutput("ar_after_err", int'(frame_err), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
